// File: rtl/axis_burst_scheduler.sv
// ---------------------------------------------------------------------------
// axis_burst_scheduler
//
// Round-robin burst scheduler that shares one AXI4-Stream master among
// CHANNELS buffered sources. A source is granted only when its upstream FIFO
// reports at least cfg_burst words. The granted source then streams exactly
// the latched burst length, with tlast on the final word. After that the
// output is re-arbitrated starting from the channel after the last grant.
//
// Ports:
//   aclk, aresetn     clock, asynchronous active-low reset
//   cfg_enable        1 = new grants allowed (never aborts a running burst)
//   cfg_burst         burst length in words, 0 = no grants
//   s_count           packed per-channel FIFO occupancy
//   s_axis_*          packed per-channel AXI4-Stream slave inputs
//   m_axis_*          AXI4-Stream master output, tid = granted channel
//   sts_busy          1 while a burst is in progress
// ---------------------------------------------------------------------------
module axis_burst_scheduler #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH       = 10,
  parameter int CHANNELS         = 4,
  parameter int ID_WIDTH         = 2
) (
  input  logic                                 aclk,
  input  logic                                 aresetn,
  input  logic                                 cfg_enable,
  input  logic [CNTR_WIDTH-1:0]                cfg_burst,
  input  logic [CHANNELS*CNTR_WIDTH-1:0]       s_count,
  input  logic [CHANNELS*AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [CHANNELS-1:0]                  s_axis_tvalid,
  output logic [CHANNELS-1:0]                  s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0]          m_axis_tdata,
  output logic                                 m_axis_tvalid,
  input  logic                                 m_axis_tready,
  output logic                                 m_axis_tlast,
  output logic [ID_WIDTH-1:0]                  m_axis_tid,
  output logic                                 sts_busy
);

  localparam int PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CNTR_WIDTH-1:0] CNTR_ONE = 1;
  localparam logic [PTR_W-1:0]      PTR_ONE  = 1;
  localparam logic [PTR_W-1:0]      PTR_MAX  = PTR_W'(CHANNELS - 1);
  localparam logic [PTR_W:0]        SUM_WRAP = (PTR_W + 1)'(CHANNELS);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t                r_state;
  logic [PTR_W-1:0]      r_ptr;
  logic [PTR_W-1:0]      r_grant;
  logic [CNTR_WIDTH-1:0] r_cnt;
  logic [CNTR_WIDTH-1:0] r_len;

  logic [CHANNELS-1:0]         w_elig;
  logic [AXIS_TDATA_WIDTH-1:0] w_src_data [CHANNELS];
  logic                        w_any;
  logic [PTR_W-1:0]            w_pick;
  logic [PTR_W:0]              w_sum;
  logic                        w_busy;
  logic                        w_last;
  logic                        w_xfer;

  // Per-channel unpacking, eligibility and ready steering
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign w_elig[gi] = cfg_enable && (cfg_burst != '0) &&
                          (s_count[gi*CNTR_WIDTH +: CNTR_WIDTH] >= cfg_burst);
      assign w_src_data[gi] = s_axis_tdata[gi*AXIS_TDATA_WIDTH +: AXIS_TDATA_WIDTH];
      assign s_axis_tready[gi] = w_busy && (r_grant == PTR_W'(gi)) && m_axis_tready;
    end
  endgenerate

  // Round-robin search ptr, ptr+1, ... with wrap. Scanning from the farthest
  // offset down lets the nearest eligible channel win by overwriting.
  always_comb begin
    w_any  = 1'b0;
    w_pick = r_ptr;
    w_sum  = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_ptr} + (PTR_W + 1)'(k);
      if (w_sum >= SUM_WRAP) begin
        w_sum = w_sum - SUM_WRAP;
      end
      if (w_elig[w_sum[PTR_W-1:0]]) begin
        w_any  = 1'b1;
        w_pick = w_sum[PTR_W-1:0];
      end
    end
  end

  // Output path is a pure pass-through of the granted source while bursting
  assign w_busy        = (r_state == ST_BURST);
  assign w_last        = w_busy && (r_cnt == (r_len - CNTR_ONE));
  assign m_axis_tvalid = w_busy && s_axis_tvalid[r_grant];
  assign m_axis_tdata  = w_busy ? w_src_data[r_grant] : '0;
  assign m_axis_tlast  = w_last;
  assign m_axis_tid    = w_busy ? ID_WIDTH'(r_grant) : '0;
  assign sts_busy      = w_busy;
  assign w_xfer        = m_axis_tvalid && m_axis_tready;

  // Control FSM. The counter stops at len-1, so len = 2^CNTR_WIDTH-1 is safe.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state <= ST_BURST;
            r_grant <= w_pick;
            r_len   <= cfg_burst;
            r_cnt   <= '0;
          end
        end
        ST_BURST: begin
          // Config and counts are not re-checked: the burst always completes
          if (w_xfer) begin
            if (w_last) begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
              r_ptr   <= (r_grant == PTR_MAX) ? '0 : (r_grant + PTR_ONE);
            end else begin
              r_cnt <= r_cnt + CNTR_ONE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_burst_scheduler.sv
// ---------------------------------------------------------------------------
// tb_axis_burst_scheduler
//
// Directed bench for axis_burst_scheduler (CHANNELS=4, CNTR_WIDTH=10).
// Each source is modelled as a word counter; its data word is
// {channel+1, word index}, so the expected output word is known per channel.
// ---------------------------------------------------------------------------
module tb_axis_burst_scheduler;

  localparam int DW = 32;
  localparam int CW = 10;
  localparam int CH = 4;
  localparam int IW = 2;

  logic              aclk;
  logic              aresetn;
  logic              cfg_enable;
  logic [CW-1:0]     cfg_burst;
  logic [CH*CW-1:0]  s_count;
  logic [CH*DW-1:0]  s_axis_tdata;
  logic [CH-1:0]     s_axis_tvalid;
  logic [CH-1:0]     s_axis_tready;
  logic [DW-1:0]     m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;
  logic [IW-1:0]     m_axis_tid;
  logic              sts_busy;

  int n_checks = 0;
  int n_errors = 0;
  int src_word [CH];

  axis_burst_scheduler #(
    .AXIS_TDATA_WIDTH(DW),
    .CNTR_WIDTH      (CW),
    .CHANNELS        (CH),
    .ID_WIDTH        (IW)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .cfg_enable   (cfg_enable),
    .cfg_burst    (cfg_burst),
    .s_count      (s_count),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tid   (m_axis_tid),
    .sts_busy     (sts_busy)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive_src();
    for (int i = 0; i < CH; i++) begin
      s_axis_tdata[i*DW +: DW] = {8'(i + 1), 24'(src_word[i])};
    end
  endtask

  task automatic set_all_counts(input int val);
    for (int i = 0; i < CH; i++) begin
      s_count[i*CW +: CW] = CW'(val);
    end
  endtask

  task automatic set_count(input int ch, input int val);
    s_count[ch*CW +: CW] = CW'(val);
  endtask

  // Waits for the grant, then drives one burst and checks every word.
  // mode 0: sink always ready; 1: sink ready 1,0,1,0..; 2: source valid 1,0,1,0..
  task automatic run_burst(input int ch, input int len, input int mode,
                           input int exp_wait, input int exp_cycles,
                           input bit clr_counts, input bit mid_cfg);
    int waited;
    int w;
    int cyc;
    logic rdy;
    logic vld;
    logic [CH-1:0] one_hot;
    one_hot = CH'(1 << ch);
    waited = 0;
    while (!sts_busy && waited < 20) begin
      tick();
      waited++;
    end
    check("grant_wait", waited, exp_wait);
    if (!sts_busy) return;
    check("grant_tid", m_axis_tid, ch);
    if (clr_counts) set_all_counts(0);
    w = 0;
    cyc = 0;
    while (w < len && cyc < 4 * len + 10) begin
      rdy = (mode == 1) ? ~cyc[0] : 1'b1;
      vld = (mode == 2) ? ~cyc[0] : 1'b1;
      m_axis_tready = rdy;
      s_axis_tvalid = '1;
      s_axis_tvalid[ch] = vld;
      #1;
      if (rdy && vld) begin
        check("xfer_tvalid", m_axis_tvalid, 1);
        check("xfer_tid", m_axis_tid, ch);
        check("xfer_tdata", m_axis_tdata, {8'(ch + 1), 24'(src_word[ch])});
        check("xfer_tlast", m_axis_tlast, (w == len - 1));
        check("xfer_tready", s_axis_tready, one_hot);
        check("xfer_busy", sts_busy, 1);
        $display("xfer tid=%0d data=%h last=%0b word=%0d/%0d",
                 m_axis_tid, m_axis_tdata, m_axis_tlast, w + 1, len);
        tick();
        src_word[ch]++;
        drive_src();
        w++;
        if (mid_cfg && w == 1) begin
          cfg_burst  = 10'd2;
          cfg_enable = 1'b0;
          set_all_counts(8);
        end
      end else begin
        check("stall_tvalid", m_axis_tvalid, vld);
        check("stall_tready", s_axis_tready, rdy ? one_hot : '0);
        tick();
      end
      cyc++;
    end
    check("burst_words", w, len);
    if (exp_cycles >= 0) check("burst_cycles", cyc, exp_cycles);
    m_axis_tready = 1'b1;
    s_axis_tvalid = '1;
    check("gap_busy", sts_busy, 0);
    check("gap_tvalid", m_axis_tvalid, 0);
  endtask

  initial begin
    aresetn       = 1'b0;
    cfg_enable    = 1'b0;
    cfg_burst     = '0;
    s_count       = '0;
    s_axis_tvalid = '1;
    m_axis_tready = 1'b1;
    for (int i = 0; i < CH; i++) src_word[i] = 0;
    drive_src();

    // Reset state
    tick();
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tready", s_axis_tready, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_tid", m_axis_tid, 0);
    check("rst_busy", sts_busy, 0);
    aresetn = 1'b1;
    tick();

    // 1: single eligible channel 2, len 4, then re-granted after one gap cycle
    cfg_enable = 1'b1;
    cfg_burst  = 10'd4;
    set_count(2, 4);
    check("t1_pre_busy", sts_busy, 0);
    run_burst(2, 4, 0, 1, 4, 0, 0);
    run_burst(2, 4, 0, 1, 4, 1, 0);

    // 2: all eligible, len 2, round robin 0,1,2,3,0 after reset
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    tick();
    cfg_burst = 10'd2;
    set_all_counts(8);
    run_burst(0, 2, 0, 1, 2, 0, 0);
    run_burst(1, 2, 0, 1, 2, 0, 0);
    run_burst(2, 2, 0, 1, 2, 0, 0);
    run_burst(3, 2, 0, 1, 2, 0, 0);
    run_burst(0, 2, 0, 1, 2, 1, 0);

    // 3: channel 1, len 3, sink ready toggling
    cfg_burst = 10'd3;
    set_count(1, 3);
    run_burst(1, 3, 1, 1, 5, 1, 0);

    // 4: len 5 on channel 3 with source stalls; config changed after word 1
    cfg_burst = 10'd5;
    set_count(3, 5);
    run_burst(3, 5, 2, 1, 9, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_no_grant", sts_busy, 0);
    end

    // 5: cfg_burst 0 blocks grants; then single-word bursts
    cfg_enable = 1'b1;
    cfg_burst  = 10'd0;
    set_all_counts(512);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_zero_busy", sts_busy, 0);
      check("t5_zero_tvalid", m_axis_tvalid, 0);
    end
    cfg_burst = 10'd1;
    run_burst(0, 1, 0, 1, 1, 0, 0);
    run_burst(1, 1, 0, 1, 1, 0, 0);
    run_burst(2, 1, 0, 1, 1, 1, 0);

    // 6: async reset mid-burst, arbitration restarts at channel 0
    cfg_burst = 10'd4;
    set_count(2, 4);
    tick();
    check("t6_grant_busy", sts_busy, 1);
    check("t6_grant_tid", m_axis_tid, 2);
    set_all_counts(0);
    tick();
    tick();
    src_word[2] += 2;
    drive_src();
    check("t6_mid_busy", sts_busy, 1);
    #2;
    aresetn = 1'b0;
    #1;
    check("t6_async_tvalid", m_axis_tvalid, 0);
    check("t6_async_tready", s_axis_tready, 0);
    check("t6_async_busy", sts_busy, 0);
    check("t6_async_tid", m_axis_tid, 0);
    #2;
    aresetn = 1'b1;
    set_all_counts(4);
    run_burst(0, 4, 0, 1, 4, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
